// File: rtl/niosii_subsys_pio_in_db_pkg.sv
// Shared constants for the debounced input PIO: register word addresses and
// edge-mode encodings.
package niosii_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RAW      = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;

  // Debounce counter width; a single-cycle debounce still needs a 1-bit counter.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/niosii_subsys_pio_in_db_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
interface niosii_subsys_pio_in_db_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/niosii_subsys_pio_in_db_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a consecutive-cycle
// counter debounce that only accepts a level held for DEBOUNCE_CYCLES cycles.
module pio_debounce_bit
  import niosii_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic raw,
  output logic stable
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign raw    = sync2_q;
  assign stable = stable_q;

endmodule

// File: rtl/niosii_subsys_pio_in_db.sv
// Debounced Avalon-MM input PIO: per-bit synchronise/debounce, edge capture
// with W1C clear, maskable level interrupt, read latency 1.
module niosii_subsys_pio_in_db
  import niosii_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [1:0]  EDGE_MODE       = EDGE_RISE
) (
  input  logic                     clk,
  input  logic                     reset,
  niosii_subsys_pio_in_db_if.slave bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_w1c;
  logic [31:0]      readdata_q;
  logic [31:0]      rd_mux;
  logic             rd_hit;
  logic             wr_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  assign rd_hit = bus.chipselect & bus.read;
  assign wr_hit = bus.chipselect & bus.write;

  always_comb begin
    edge_evt = '0;
    case (EDGE_MODE)
      EDGE_RISE: edge_evt = stable & ~stable_d_q;
      EDGE_FALL: edge_evt = ~stable & stable_d_q;
      default:   edge_evt = stable ^ stable_d_q;
    endcase
  end

  assign edge_w1c = (wr_hit && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      ADDR_DATA:     rd_mux = 32'(stable);
      ADDR_IRQ_MASK: rd_mux = 32'(irq_mask_q);
      ADDR_RAW:      rd_mux = 32'(raw);
      ADDR_EDGE:     rd_mux = 32'(edge_cap_q);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      stable_d_q <= stable;
      // A new event wins over a simultaneous clear of the same bit.
      edge_cap_q <= (edge_cap_q & ~edge_w1c) | edge_evt;
      if (wr_hit && bus.address == ADDR_IRQ_MASK) begin
        irq_mask_q <= bus.writedata[WIDTH-1:0];
      end
      if (rd_hit) begin
        readdata_q <= rd_mux;
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

endmodule
